// File: rtl/foxtrot_pkg.sv
// rtl/foxtrot_pkg.sv - shared FU package: multiply op classes, decode constants, result record (MUL_FU_HIGH_EN adds SMULH/UMULH decode)
package foxtrot_pkg;

  localparam int unsigned FU_INST_ID_BITS = 6;
  localparam int unsigned FU_PRN_BITS     = 6;

  // inst[31:21] match values for the multiply family
  localparam logic [10:0] DEC_MADD_MSUB = 11'b10011011000;
  localparam logic [10:0] DEC_SMULH     = 11'b10011011010;
  localparam logic [10:0] DEC_UMULH     = 11'b10011011110;

  typedef enum logic [2:0] {
    MUL_MADD,
    MUL_MSUB,
    MUL_SMULH,
    MUL_UMULH,
    MUL_NONE
  } mul_op_e;

  typedef struct packed {
    logic [FU_INST_ID_BITS-1:0] inst_id;
    logic [FU_PRN_BITS-1:0]     prn;
    logic [63:0]                value;
  } fu_result_t;

  // o0 is inst[15]; it separates MSUB from MADD
  function automatic mul_op_e mul_decode(input logic [10:0] opc, input logic o0);
    if (opc == DEC_MADD_MSUB) return o0 ? MUL_MSUB : MUL_MADD;
`ifdef MUL_FU_HIGH_EN
    if (opc == DEC_SMULH) return MUL_SMULH;
    if (opc == DEC_UMULH) return MUL_UMULH;
`endif
    return MUL_NONE;
  endfunction

endpackage

// File: rtl/mul_fu_if.sv
// rtl/mul_fu_if.sv - issue and result-bus signals between an issue queue and the multiply unit
interface mul_fu_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
);
  logic                                   fu_ready;
  logic                                   inst_valid;
  logic [INST_ID_BITS-1:0]                inst_id;
  logic [31:0]                            inst;
  logic [MAX_OPERANDS-1:0][63:0]          op;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn;
  logic [63:0]                            pc;
  logic                                   result_valid;
  logic [INST_ID_BITS-1:0]                result_inst_id;
  logic [PRN_BITS-1:0]                    result_prn;
  logic [63:0]                            result_value;
  logic                                   result_grant;

  modport master (
    input  fu_ready, result_valid, result_inst_id, result_prn, result_value,
    output inst_valid, inst_id, inst, op, out_prn, pc, result_grant
  );

  modport slave (
    output fu_ready, result_valid, result_inst_id, result_prn, result_value,
    input  inst_valid, inst_id, inst, op, out_prn, pc, result_grant
  );
endinterface

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - in-order result FIFO shared by the FUs on the result bus
module result_fifo #(
  parameter int WIDTH = 76,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             pop_ok;

  // Pop only a real entry; a push into an empty FIFO is not visible to a same-edge pop
  assign pop_ok = pop_i && (cnt_q != '0);

  // Pointer and count next state; pointers wrap naturally at a power-of-2 depth
  always_comb begin
    wr_d  = push_i ? wr_q + PW'(1) : wr_q;
    rd_d  = pop_ok ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_ok);
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/mul_fu.sv
// rtl/mul_fu.sv - fixed-latency ARM64 multiply unit with credit-protected result FIFO (MUL_FU_HIGH_EN adds SMULH/UMULH)
module mul_fu
  import foxtrot_pkg::*;
#(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int LATENCY      = 3,
  parameter int OUT_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      rst,
  mul_fu_if.slave   fu_bus
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int ENT_W = INST_ID_BITS + PRN_BITS + 64;

  logic                    accept, push;
  logic [63:0]             rn, rm, ra, prod_lo, prod_hi, in_val, out_val;
  mul_op_e                 in_op;
  logic [LATENCY-1:0]      pv_q, pv_d;
  logic [INST_ID_BITS-1:0] pid_q  [LATENCY];
  logic [PRN_BITS-1:0]     pprn_q [LATENCY];
  mul_op_e                 pop_q  [LATENCY];
  logic [63:0]             pval_q [LATENCY];
  logic [CNT_W-1:0]        inflight_q, inflight_d, fifo_cnt;
  logic [ENT_W-1:0]        head;
  logic [INST_ID_BITS-1:0] h_id;
  logic [PRN_BITS-1:0]     h_prn;
  logic [63:0]             h_val;
  logic                    unused_in;

  assign rn     = fu_bus.op[0];
  assign rm     = fu_bus.op[1];
  assign ra     = fu_bus.op[2];
  assign accept = fu_bus.inst_valid && fu_bus.fu_ready;
  assign push   = pv_q[LATENCY-1];

  assign unused_in = ^{fu_bus.pc, fu_bus.inst[20:16], fu_bus.inst[14:0], fu_bus.out_prn, fu_bus.op};

`ifdef MUL_FU_HIGH_EN
  logic signed [64:0]  rn_x, rm_x;
  logic signed [129:0] prod_w;
  logic                unused_prod;

  // One 65x65 signed multiply serves both forms: the extra bit is the sign only for SMULH
  always_comb begin
    rn_x   = {(in_op == MUL_SMULH) & rn[63], rn};
    rm_x   = {(in_op == MUL_SMULH) & rm[63], rm};
    prod_w = 130'(rn_x) * 130'(rm_x);
  end
  assign prod_lo     = prod_w[63:0];
  assign prod_hi     = prod_w[127:64];
  assign unused_prod = ^prod_w[129:128];
`else
  assign prod_lo = rn * rm;
  assign prod_hi = '0;
`endif

  // Decode and form the final value at issue; the pipe stages only carry it
  always_comb begin
    in_val = '0;
    in_op  = mul_decode(fu_bus.inst[31:21], fu_bus.inst[15]);
    case (in_op)
      MUL_MADD:             in_val = ra + prod_lo;
      MUL_MSUB:             in_val = ra - prod_lo;
      MUL_SMULH, MUL_UMULH: in_val = prod_hi;
      default:              in_val = '0;
    endcase
  end

  // Valid bits advance one stage per cycle with no stalls
  always_comb begin
    pv_d    = '0;
    pv_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) pv_d[i] = pv_q[i-1];
  end

  // Pipe valid register
  always_ff @(posedge clk) begin
    if (rst) pv_q <= '0;
    else     pv_q <= pv_d;
  end

  // Pipe payload; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    pid_q[0]  <= fu_bus.inst_id;
    pprn_q[0] <= fu_bus.out_prn[0];
    pop_q[0]  <= in_op;
    pval_q[0] <= in_val;
    for (int i = 1; i < LATENCY; i++) begin
      pid_q[i]  <= pid_q[i-1];
      pprn_q[i] <= pprn_q[i-1];
      pop_q[i]  <= pop_q[i-1];
      pval_q[i] <= pval_q[i-1];
    end
  end

  assign out_val = (pop_q[LATENCY-1] == MUL_NONE) ? 64'd0 : pval_q[LATENCY-1];

  result_fifo #(.WIDTH(ENT_W), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({pid_q[LATENCY-1], pprn_q[LATENCY-1], out_val}),
    .pop_i       (fu_bus.result_grant),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  // In-flight count: net of this cycle's accept and FIFO push
  always_comb inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(push);

  // In-flight count register
  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  // Credits: every accepted op owns a FIFO slot until it is popped
  assign fu_bus.fu_ready = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CNT_W+1)'(OUT_DEPTH);

  assign {h_id, h_prn, h_val}  = head;
  assign fu_bus.result_valid   = (fifo_cnt != '0);
  assign fu_bus.result_inst_id = fu_bus.result_valid ? h_id  : '0;
  assign fu_bus.result_prn     = fu_bus.result_valid ? h_prn : '0;
  assign fu_bus.result_value   = fu_bus.result_valid ? h_val : '0;
endmodule

// File: tb/tb_mul_fu.sv
// tb/tb_mul_fu.sv - self-checking bench for mul_fu against a behavioural result model
module tb_mul_fu;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_fu_if #(.INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3)) f();

  mul_fu #(.INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .fu_bus (f)
  );

  typedef struct {
    logic [5:0]  id;
    logic [5:0]  prn;
    logic [63:0] val;
    int          cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   outstanding = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] ref_val(input logic [31:0] ins, input logic [63:0] rn, rm, ra);
    case (ins[31:21])
      11'b10011011000: return ins[15] ? ra - rn * rm : ra + rn * rm;
`ifdef MUL_FU_HIGH_EN
      11'b10011011010: begin
        logic signed [127:0] sa, sb;
        logic [127:0]        p;
        sa = $signed(rn);
        sb = $signed(rm);
        p  = sa * sb;
        return p[127:64];
      end
      11'b10011011110: begin
        logic [127:0] p;
        p = {64'd0, rn} * {64'd0, rm};
        return p[127:64];
      end
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    case ($urandom_range(0, 4))
      0:       return 32'h9B000000 | ($urandom & 32'h001F7FFF);
      1:       return 32'h9B008000 | ($urandom & 32'h001F7FFF);
      2:       return 32'h9B400000 | ($urandom & 32'h001FFFFF);
      3:       return 32'h9BC00000 | ($urandom & 32'h001FFFFF);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 3))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Records accepted issues (with the model's value) and granted results, one cycle index each
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (f.inst_valid && f.fu_ready) begin
        exp_q.push_back('{f.inst_id, f.out_prn[0], ref_val(f.inst, f.op[0], f.op[1], f.op[2]), cyc});
        outstanding++;
      end
      if (f.result_valid && f.result_grant) begin
        obs_q.push_back('{f.result_inst_id, f.result_prn, f.result_value, cyc});
        outstanding--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] rn, rm, ra, input logic [5:0] id, prn);
    f.inst_valid = 1'b1;
    f.inst       = ins;
    f.op[0]      = rn;
    f.op[1]      = rm;
    f.op[2]      = ra;
    f.inst_id    = id;
    f.out_prn[0] = prn;
    f.out_prn[1] = 6'($urandom);
    f.out_prn[2] = 6'($urandom);
    f.pc         = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] rn, rm, ra, input logic [5:0] id, prn);
    int guard = 0;
    while (f.fu_ready !== 1'b1 && guard < 50) begin
      f.inst_valid = 1'b0;
      step();
      guard++;
    end
    drive(ins, rn, rm, ra, id, prn);
    step();
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    n_cmp++; if (f.fu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_fu_ready got=%b want=1", f.fu_ready); end
    n_cmp++; if (f.result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_result_valid got=%b want=0", f.result_valid); end
    n_cmp++; if (f.result_prn !== 6'd0) begin n_bad++; $display("FAIL reset_result_prn got=%h want=0", f.result_prn); end
    n_cmp++; if (f.result_inst_id !== 6'd0) begin n_bad++; $display("FAIL reset_result_inst_id got=%h want=0", f.result_inst_id); end
    n_cmp++; if (f.result_value !== 64'd0) begin n_bad++; $display("FAIL reset_result_value got=%h want=0", f.result_value); end
  endtask

  task automatic test_single_madd();
    bit ok;
    clear_logs();
    f.result_grant = 1'b1;
    drive(32'h9B051C83, 64'd3, 64'd5, 64'd7, 6'd4, 6'd9);
    step();
    f.inst_valid = 1'b0;
    wait_obs(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL madd_timeout got=%0d results want=1", obs_q.size()); end
    if (ok) begin
      n_cmp++; if (obs_q[0].val !== 64'd22) begin n_bad++; $display("FAIL madd_value got=%h want=%h", obs_q[0].val, 64'd22); end
      n_cmp++; if (obs_q[0].prn !== 6'd9) begin n_bad++; $display("FAIL madd_prn got=%0d want=9", obs_q[0].prn); end
      n_cmp++; if (obs_q[0].id !== 6'd4) begin n_bad++; $display("FAIL madd_inst_id got=%0d want=4", obs_q[0].id); end
      // the accept is logged the cycle before its edge, the result the cycle after edge+LAT
      n_cmp++; if (exp_q.size() != 1 || obs_q[0].cyc - exp_q[0].cyc != LAT + 1) begin
        n_bad++; $display("FAIL madd_latency got=%0d want=%0d", exp_q.size() == 1 ? obs_q[0].cyc - exp_q[0].cyc : -1, LAT + 1);
      end
      n_cmp++; if (f.result_valid !== 1'b0) begin n_bad++; $display("FAIL madd_one_cycle got=%b want=0", f.result_valid); end
    end
    repeat (4) step();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL madd_count got=%0d want=1", obs_q.size()); end
  endtask

  task automatic test_forms();
    bit          ok;
    logic [31:0] t_ins [3];
    logic [63:0] t_rn  [3];
    logic [63:0] t_rm  [3];
    logic [63:0] t_ra  [3];
    logic [63:0] t_exp [3];
    int          total;
    t_ins[0] = 32'h9B008000; t_rn[0] = 64'd2;  t_rm[0] = 64'd3;  t_ra[0] = 64'd1;
    t_exp[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    t_ins[1] = 32'h9BC00000; t_rn[1] = '1;     t_rm[1] = '1;     t_ra[1] = {$urandom, $urandom};
    t_ins[2] = 32'h9B400000; t_rn[2] = '1;     t_rm[2] = 64'd2;  t_ra[2] = {$urandom, $urandom};
`ifdef MUL_FU_HIGH_EN
    t_exp[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    t_exp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    t_exp[1] = 64'd0;
    t_exp[2] = 64'd0;
`endif
    total = 13;
    clear_logs();
    f.result_grant = 1'b1;
    for (int i = 0; i < 3; i++) issue(t_ins[i], t_rn[i], t_rm[i], t_ra[i], 6'(i), 6'($urandom));
    for (int i = 3; i < total; i++) issue(rand_inst(), rand64(), rand64(), rand64(), 6'(i), 6'($urandom));
    f.inst_valid = 1'b0;
    wait_obs(total, ok);
    n_cmp++; if (!ok || exp_q.size() != total) begin
      n_bad++; $display("FAIL forms_count got=%0d/%0d want=%0d", exp_q.size(), obs_q.size(), total);
    end
    if (ok && exp_q.size() == total) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (obs_q[i].val !== t_exp[i]) begin n_bad++; $display("FAIL forms_fixed_%0d got=%h want=%h", i, obs_q[i].val, t_exp[i]); end
      end
      for (int i = 0; i < total; i++) begin
        n_cmp++;
        if ({obs_q[i].id, obs_q[i].prn, obs_q[i].val} !== {exp_q[i].id, exp_q[i].prn, exp_q[i].val}) begin
          n_bad++;
          $display("FAIL forms_model_%0d got id=%0d prn=%0d val=%h want id=%0d prn=%0d val=%h",
                   i, obs_q[i].id, obs_q[i].prn, obs_q[i].val, exp_q[i].id, exp_q[i].prn, exp_q[i].val);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    f.result_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(rand_inst(), rand64(), rand64(), rand64(), 6'(i), 6'($urandom));
      step();
    end
    f.inst_valid = 1'b0;
    n_cmp++; if (exp_q.size() != DEPTH) begin n_bad++; $display("FAIL bp_accepts got=%0d want=%0d", exp_q.size(), DEPTH); end
    n_cmp++; if (f.fu_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got=%b want=0", f.fu_ready); end
    n_cmp++; if (f.result_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held got=%b want=1", f.result_valid); end
    f.result_grant = 1'b1;
    step();
    n_cmp++; if (f.fu_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop got=%b want=1", f.fu_ready); end
    wait_obs(DEPTH, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout got=%0d want=%0d", obs_q.size(), DEPTH); end
    if (ok && exp_q.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if ({obs_q[i].id, obs_q[i].prn, obs_q[i].val} !== {exp_q[i].id, exp_q[i].prn, exp_q[i].val}
            || obs_q[i].cyc != obs_q[0].cyc + i) begin
          n_bad++;
          $display("FAIL bp_result_%0d got id=%0d val=%h cyc=%0d want id=%0d val=%h cyc=%0d",
                   i, obs_q[i].id, obs_q[i].val, obs_q[i].cyc, exp_q[i].id, exp_q[i].val, obs_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_streaming();
    bit ok;
    int sent  = 0;
    int guard = 0;
    clear_logs();
    f.result_grant = 1'b1;
    while (sent < 16 && guard < 200) begin
      n_cmp++;
      if (f.fu_ready !== (outstanding < DEPTH)) begin
        n_bad++; $display("FAIL stream_ready got=%b want=%b outstanding=%0d", f.fu_ready, outstanding < DEPTH, outstanding);
      end
      if (f.fu_ready === 1'b1) begin
        drive(rand_inst(), rand64(), rand64(), rand64(), 6'(sent), 6'($urandom));
        sent++;
      end else begin
        f.inst_valid = 1'b0;
      end
      step();
      guard++;
    end
    f.inst_valid = 1'b0;
    wait_obs(16, ok);
    n_cmp++; if (!ok || exp_q.size() != 16) begin
      n_bad++; $display("FAIL stream_count got=%0d/%0d want=16", exp_q.size(), obs_q.size());
    end
    if (ok && exp_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if ({obs_q[i].id, obs_q[i].prn, obs_q[i].val} !== {exp_q[i].id, exp_q[i].prn, exp_q[i].val}) begin
          n_bad++;
          $display("FAIL stream_result_%0d got id=%0d val=%h want id=%0d val=%h",
                   i, obs_q[i].id, obs_q[i].val, exp_q[i].id, exp_q[i].val);
        end
      end
    end
  endtask

  task automatic test_unsupported();
    bit ok;
    clear_logs();
    f.result_grant = 1'b1;
    issue(32'hD503201F, rand64(), rand64(), rand64(), 6'd33, 6'd21);
    f.inst_valid = 1'b0;
    wait_obs(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL nop_timeout got=%0d want=1", obs_q.size()); end
    if (ok) begin
      n_cmp++; if (obs_q[0].val !== 64'd0) begin n_bad++; $display("FAIL nop_value got=%h want=0", obs_q[0].val); end
      n_cmp++; if (obs_q[0].prn !== 6'd21 || obs_q[0].id !== 6'd33) begin
        n_bad++; $display("FAIL nop_tags got prn=%0d id=%0d want prn=21 id=33", obs_q[0].prn, obs_q[0].id);
      end
    end
    repeat (3) step();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL nop_count got=%0d want=1", obs_q.size()); end
  endtask

  task automatic test_reset_midflight();
    bit seen_valid = 1'b0;
    clear_logs();
    f.result_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h9B000000, rand64(), rand64(), rand64(), 6'(40 + i), 6'(i));
      step();
    end
    drive(32'h9B000000, rand64(), rand64(), rand64(), 6'd50, 6'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    f.inst_valid = 1'b0;
    n_cmp++; if (f.fu_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", f.fu_ready); end
    for (int i = 0; i < 12; i++) begin
      if (f.result_valid !== 1'b0) seen_valid = 1'b1;
      step();
    end
    n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=1 want=0"); end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rstmid_results got=%0d want=0", obs_q.size()); end
  endtask

  initial begin
    f.inst_valid   = 1'b0;
    f.inst         = '0;
    f.inst_id      = '0;
    f.op           = '0;
    f.out_prn      = '0;
    f.pc           = '0;
    f.result_grant = 1'b0;
    rst            = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    test_reset();
    test_single_madd();
    test_forms();
    test_backpressure();
    test_streaming();
    test_unsupported();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
